ear_conditioner: RTL
====================

EAR_CONDITIONER -- requirements
Module: ear_conditioner

Interface
REQ-001 Parameter FILTER, default 4: consecutive ce ticks a new input level must persist before it is accepted (range 1..15).
REQ-002 Parameter PW, default 12: width of the period counter and of the period output.
REQ-003 Parameter PMIN, default 20: minimum valid half-period, in ce ticks.
REQ-004 Parameter PMAX, default 400: maximum valid half-period, in ce ticks.
REQ-005 Parameter NACT, default 8: consecutive valid half-periods required to assert active (range 1..15).
REQ-006 Parameter TIMEOUT, default 2047: ce ticks without an edge before active drops; TIMEOUT SHALL satisfy PMAX < TIMEOUT < 2^PW-1.
REQ-007 clock  input  1  system clock; one clock domain.
REQ-008 reset  input  1  synchronous, active-low reset.
REQ-009 ce  input  1  sample tick, one clock wide.
REQ-010 ear_in  input  1  raw tape input, asynchronous to clock.
REQ-011 motor  input  1  tape motor enable; 0 = conditioner idle.
REQ-012 ear  output  1  filtered level that drives the audio mixer's ear input.
REQ-013 edge  output  1  one-clock pulse on every change of ear.
REQ-014 period  output  PW  ce ticks measured between the last two edges.
REQ-015 active  output  1  valid tape carrier is present.

Function
REQ-016 ear_in SHALL pass through a 2-flop synchronizer on every clock, independent of ce and motor; ear and edge therefore lag ear_in by at least 2 clocks.
REQ-017 Glitch filter: on each ce tick, while motor=1, the synchronized level is compared with ear.
  - Level differs: a 4-bit counter increments.
  - Level matches: the counter clears to 0.
  - Counter reaches FILTER: ear takes the synchronized level and the counter clears in the same clock.
REQ-018 An input pulse shorter than FILTER ce ticks SHALL never change ear.
REQ-019 edge SHALL be 1 for exactly the clock in which ear changes, and 0 at all other times.
REQ-020 Period counter: increments on each ce tick while motor=1 and saturates at 2^PW-1, with no wrap.
  - On an edge, period loads the counter value and the counter restarts at 1 when ce is also high that clock, otherwise at 0.
REQ-021 An edge is valid when PMIN <= counter <= PMAX, evaluated on the counter value before the reload.
REQ-022 Valid-edge counter: increments on a valid edge, clears on an invalid edge, and saturates at NACT.
REQ-023 Activity FSM with states IDLE and LOCK.
  - IDLE -> LOCK when the valid-edge counter reaches NACT; active=1 in LOCK only.
  - LOCK -> IDLE when the period counter reaches TIMEOUT, or on an edge longer than PMAX.
  - An edge shorter than PMIN in LOCK clears the valid-edge counter but does not leave LOCK.
  - Entering IDLE clears the valid-edge counter.
REQ-024 motor=0: ear forced to 0 and edge forced to 0 in the next clock; filter, period and valid-edge counters clear; FSM goes to IDLE; period holds its last value.
REQ-025 A forced ear 1->0 caused by motor falling SHALL NOT generate an edge pulse.
REQ-026 Edge and timeout in the same clock: the edge wins; the counter reloads and the FSM stays in LOCK when that edge is valid.
REQ-027 ce=0 freezes the filter, period and valid-edge counters; only the synchronizer and the output registers keep clocking.

Reset
REQ-028 With reset=0 at a clock edge, the following SHALL all clear: synchronizer flops, filter, period and valid-edge counters.
REQ-029 Outputs after that clock: ear=0, edge=0, period=0, active=0, FSM=IDLE.
REQ-030 Reset SHALL take priority over motor, ce and an edge occurring in the same clock.
REQ-031 Reset asserted mid-lock SHALL drop active in the following clock.
REQ-032 After reset is released, the first edge SHALL update period but SHALL NOT count as valid unless its interval meets REQ-021.

Verification
REQ-033 Glitch rejection: motor=1, ce every clock, ear_in high for 3 ce ticks then low -> ear stays 0 and edge never pulses.
REQ-034 Acceptance latency: ear_in held 0->1 -> ear=1 and edge=1 exactly 2+4 clocks after the input change, then edge=0.
REQ-035 Lock: 8 full cycles of square wave with half-period 100 ticks -> active=1 on the 8th valid edge; period=100.
REQ-036 Timeout: in LOCK, ear_in frozen -> active=0 exactly when the period counter reaches 2047; period holds 100.
REQ-037 Motor drop: in LOCK, motor 1->0 -> next clock ear=0, active=0, edge=0, period unchanged.
REQ-038 Saturation and reset: ear_in static for 5000 ticks with motor=1 -> period counter saturates at 4095; reset=0 for 1 clock -> every output 0.

Source files
------------

// File: rtl/ear_conditioner.sv
// Tape EAR input conditioner: synchronizes and glitch-filters the raw tape level,
// measures half-periods between edges and flags when a steady carrier is present.
module ear_conditioner #(
   parameter int FILTER  = 4,
   parameter int PW      = 12,
   parameter int PMIN    = 20,
   parameter int PMAX    = 400,
   parameter int NACT    = 8,
   parameter int TIMEOUT = 2047
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ce,
   input  logic          ear_in,
   input  logic          motor,
   output logic          ear,
   output logic          ear_edge,
   output logic [PW-1:0] period,
   output logic          active
);

   typedef enum logic {IDLE, LOCK} state_t;

   localparam logic [PW-1:0] PCOUNT_MAX = '1;

   state_t          state, stateNext;
   logic            syncA, syncB;
   logic [3:0]      filterCount, filterNext;
   logic [PW-1:0]   periodCount, periodCountNext;
   logic [3:0]      validCount, validNext;
   logic            earNext, accept, edgeValid, edgeLong;

   // Filter, period and valid-edge datapath; counters only move on a ce tick with the motor running
   always_comb begin
      filterNext      = filterCount;
      earNext         = ear;
      accept          = 1'b0;
      periodCountNext = periodCount;
      validNext       = validCount;
      edgeValid       = 1'b0;
      edgeLong        = 1'b0;
      if (!motor) begin
         filterNext      = '0;
         earNext         = 1'b0;
         periodCountNext = '0;
         validNext       = '0;
      end else if (ce) begin
         if (syncB != ear) begin
            if (filterCount + 4'd1 == 4'(FILTER)) begin
               accept     = 1'b1;
               earNext    = syncB;
               filterNext = '0;
            end else begin
               filterNext = filterCount + 4'd1;
            end
         end else begin
            filterNext = '0;
         end
         if (accept) begin
            periodCountNext = PW'(1);
            edgeValid = (periodCount >= PW'(PMIN)) && (periodCount <= PW'(PMAX));
            edgeLong  = (periodCount > PW'(PMAX));
            if (!edgeValid)
               validNext = '0;
            else if (validCount != 4'(NACT))
               validNext = validCount + 4'd1;
         end else if (periodCount != PCOUNT_MAX) begin
            periodCountNext = periodCount + PW'(1);
         end
      end
   end

   // Activity FSM next state; an edge in the same clock overrides the timeout
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (motor && validNext == 4'(NACT))
               stateNext = LOCK;
         end
         LOCK: begin
            if (!motor)
               stateNext = IDLE;
            else if (accept) begin
               if (edgeLong)
                  stateNext = IDLE;
            end else if (periodCountNext >= PW'(TIMEOUT))
               stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // Datapath registers; period only reloads on an accepted edge so it survives motor-off
   always_ff @(posedge clock) begin
      if (!reset) begin
         syncA       <= 1'b0;
         syncB       <= 1'b0;
         filterCount <= '0;
         ear         <= 1'b0;
         ear_edge    <= 1'b0;
         periodCount <= '0;
         period      <= '0;
         validCount  <= '0;
      end else begin
         syncA       <= ear_in;
         syncB       <= syncA;
         filterCount <= filterNext;
         ear         <= earNext;
         ear_edge    <= accept;
         periodCount <= periodCountNext;
         if (accept)
            period <= periodCount;
         validCount  <= (state == LOCK && stateNext == IDLE) ? '0 : validNext;
      end
   end

   assign active = (state == LOCK);

endmodule
